// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Two-port round-robin arbiter for the single data-memory port.
//             Port 0 = core load/store, port 1 = loader/debug DMA. Bounded
//             hold (MAX_HOLD) keeps a streaming port from starving the other.
//             Zero-cycle issue latency, one-cycle read data return.
//  Options  : MEM_ARB_LOCK_EN - adds r0_lock_i/r1_lock_i so the current owner
//             can keep the port for an atomic read-modify-write sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    // port 0 : core load/store
    input  logic          r0_req_i,
    input  logic          r0_we_i,
    input  logic [AW-1:0] r0_addr_i,
    input  logic [DW-1:0] r0_wdata_i,
`ifdef MEM_ARB_LOCK_EN
    input  logic          r0_lock_i,
`endif
    output logic          r0_gnt_o,
    output logic          r0_rvalid_o,
    output logic [DW-1:0] r0_rdata_o,
    // port 1 : loader / debug DMA
    input  logic          r1_req_i,
    input  logic          r1_we_i,
    input  logic [AW-1:0] r1_addr_i,
    input  logic [DW-1:0] r1_wdata_i,
`ifdef MEM_ARB_LOCK_EN
    input  logic          r1_lock_i,
`endif
    output logic          r1_gnt_o,
    output logic          r1_rvalid_o,
    output logic [DW-1:0] r1_rdata_o,
    // memory side
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_rd_en_o,
    output logic          mem_wr_en_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    owner_e        owner_q, owner_d;
    logic          rr_q, rr_d;          // 0 = favour P0, 1 = favour P1
    logic [HW-1:0] hold_q, hold_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_port_q, rd_port_d;

    logic w_gnt0;
    logic w_gnt1;
    logic w_any;
    logic w_we;
    logic w_lock0;
    logic w_lock1;
    logic w_locked_win;
    logic w_other_req;
    owner_e w_new_owner;

`ifdef MEM_ARB_LOCK_EN
    assign w_lock0 = r0_lock_i;
    assign w_lock1 = r1_lock_i;
`else
    assign w_lock0 = 1'b0;
    assign w_lock1 = 1'b0;
`endif

    // Grant selection: lone requester wins; on contention the owner keeps the
    // port until its hold budget is spent (or while locked), else rr_ptr decides.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r0_req_i && r1_req_i) begin
            case (owner_q)
                OWN_P0: begin
                    if (w_lock0 || (hold_q < HOLD_MAX)) w_gnt0 = 1'b1;
                    else                                w_gnt1 = 1'b1;
                end
                OWN_P1: begin
                    if (w_lock1 || (hold_q < HOLD_MAX)) w_gnt1 = 1'b1;
                    else                                w_gnt0 = 1'b1;
                end
                default: begin
                    if (rr_q) w_gnt1 = 1'b1;
                    else      w_gnt0 = 1'b1;
                end
            endcase
        end else begin
            w_gnt0 = r0_req_i;
            w_gnt1 = r1_req_i;
        end
        // grants are combinational, so force them low while reset is held
        if (reset_i) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign w_any = w_gnt0 | w_gnt1;
    assign w_we  = (w_gnt0 & r0_we_i) | (w_gnt1 & r1_we_i);

    assign r0_gnt_o    = w_gnt0;
    assign r1_gnt_o    = w_gnt1;
    assign mem_addr_o  = w_gnt0 ? r0_addr_i  : (w_gnt1 ? r1_addr_i  : '0);
    assign mem_wdata_o = w_gnt0 ? r0_wdata_i : (w_gnt1 ? r1_wdata_i : '0);
    assign mem_rd_en_o = w_any & ~w_we;
    assign mem_wr_en_o = w_any &  w_we;

    // Read return is steered to the port that issued the read last cycle.
    assign r0_rvalid_o = rd_pend_q & ~rd_port_q;
    assign r1_rvalid_o = rd_pend_q &  rd_port_q;
    assign r0_rdata_o  = r0_rvalid_o ? mem_rdata_i : '0;
    assign r1_rdata_o  = r1_rvalid_o ? mem_rdata_i : '0;

    assign w_new_owner  = w_gnt1 ? OWN_P1 : OWN_P0;
    assign w_other_req  = w_gnt1 ? r0_req_i : r1_req_i;
    assign w_locked_win = ((owner_q == OWN_P0) && w_gnt0 && w_lock0) ||
                          ((owner_q == OWN_P1) && w_gnt1 && w_lock1);

    // Next-state: ownership, hold budget, round-robin pointer, read tracking.
    always_comb begin
        owner_d   = owner_q;
        rr_d      = rr_q;
        hold_d    = hold_q;
        rd_pend_d = w_any & ~w_we;
        rd_port_d = w_any ? w_gnt1 : rd_port_q;
        if (w_any) begin
            owner_d = w_new_owner;
            if (w_new_owner == owner_q) begin
                if (w_locked_win) begin
                    hold_d = hold_q;
                end else if (w_other_req) begin
                    hold_d = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + HW'(1);
                end else begin
                    hold_d = '0;
                end
            end else begin
                hold_d = HW'(1);
                rr_d   = w_gnt0;    // loser is favoured next time
            end
        end else if (!r0_req_i && !r1_req_i) begin
            owner_d = OWN_NONE;
            hold_d  = '0;
        end
    end

    // State registers; a read in flight at reset is discarded.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            owner_q   <= OWN_NONE;
            rr_q      <= 1'b0;
            hold_q    <= '0;
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            hold_q    <= hold_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

    // A requester must hold its request until it is granted.
    a_r0_req_held: assert property (@(posedge clk_i) disable iff (reset_i)
        (r0_req_i && !r0_gnt_o) |=> r0_req_i);
    a_r1_req_held: assert property (@(posedge clk_i) disable iff (reset_i)
        (r1_req_i && !r1_gnt_o) |=> r1_req_i);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Directed self-checking bench for mem_port_arbiter with a small
//             behavioural memory (one-cycle read latency).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd_en, mem_wr_en;
    logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_LOCK_EN
    logic          r0_lock, r1_lock;
`endif

    int errors;
    int checks;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(8)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .r0_req_i    (r0_req),
        .r0_we_i     (r0_we),
        .r0_addr_i   (r0_addr),
        .r0_wdata_i  (r0_wdata),
`ifdef MEM_ARB_LOCK_EN
        .r0_lock_i   (r0_lock),
`endif
        .r0_gnt_o    (r0_gnt),
        .r0_rvalid_o (r0_rvalid),
        .r0_rdata_o  (r0_rdata),
        .r1_req_i    (r1_req),
        .r1_we_i     (r1_we),
        .r1_addr_i   (r1_addr),
        .r1_wdata_i  (r1_wdata),
`ifdef MEM_ARB_LOCK_EN
        .r1_lock_i   (r1_lock),
`endif
        .r1_gnt_o    (r1_gnt),
        .r1_rvalid_o (r1_rvalid),
        .r1_rdata_o  (r1_rdata),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rd_en_o (mem_rd_en),
        .mem_wr_en_o (mem_wr_en),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 64 words, unwritten words return a default pattern.
    logic [DW-1:0] mem_arr [0:63];
    logic [63:0]   mem_vld;
    logic          mem_init;

    function automatic logic [DW-1:0] dflt_word(input logic [5:0] idx);
        if (idx == 6'd4) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | {24'd0, idx, 2'b00};
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            mem_vld   <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_wr_en) begin
                mem_arr[mem_addr[7:2]] <= mem_wdata;
                mem_vld[mem_addr[7:2]] <= 1'b1;
            end
            if (mem_rd_en)
                mem_rdata <= mem_vld[mem_addr[7:2]] ? mem_arr[mem_addr[7:2]]
                                                    : dflt_word(mem_addr[7:2]);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
        r0_lock = 1'b0; r1_lock = 1'b0;
`endif
    endtask

    task automatic pulse_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_rd_en, mem_wr_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_rd_en, mem_wr_en});
        end
        checks++;
        if (mem_addr !== 32'd0 || r0_rdata !== 32'd0 || r1_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h r0d=%h r1d=%h want 0", mem_addr, r0_rdata, r1_rdata);
        end
        tick();
    endtask

    task automatic test_single_read;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10;
        @(negedge clk);
        checks++;
        if ({r0_gnt, r1_gnt, mem_rd_en, mem_wr_en} !== 4'b1010) begin
            errors++;
            $display("FAIL rd_issue: gnt0,gnt1,rd,wr got %b want 1010",
                     {r0_gnt, r1_gnt, mem_rd_en, mem_wr_en});
        end
        checks++;
        if (mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL rd_addr: got %h want 00000010", mem_addr);
        end
        tick();
        r0_req = 1'b0;
        @(negedge clk);
        checks++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hDEAD_BEEF || r1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_return: rv0=%b d0=%h rv1=%b want 1 deadbeef 0",
                     r0_rvalid, r0_rdata, r1_rvalid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (r0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_single_pulse: rv0=%b want 0", r0_rvalid);
        end
        tick();
    endtask

    task automatic test_contention;
        pulse_reset();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h80; r0_wdata = 32'h1111_0000;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h84; r1_wdata = 32'h2222_0000;
        for (int c = 0; c < 32; c++) begin
            logic exp0;
            exp0 = ((c / 8) % 2) == 0;
            @(negedge clk);
            checks++;
            if (r0_gnt !== exp0 || r1_gnt !== !exp0 || mem_wr_en !== 1'b1) begin
                errors++;
                $display("FAIL rr_cycle%0d: gnt0=%b gnt1=%b wr=%b want %b %b 1",
                         c, r0_gnt, r1_gnt, mem_wr_en, exp0, !exp0);
            end
            tick();
        end
        // r0 lost the last arbitration and keeps requesting until served
        r1_req = 1'b0;
        @(negedge clk);
        checks++;
        if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rr_tail: gnt0=%b gnt1=%b want 1 0", r0_gnt, r1_gnt);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_write_then_read;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h20; r1_wdata = 32'h1234;
        @(negedge clk);
        checks++;
        if (r1_gnt !== 1'b1 || mem_wr_en !== 1'b1 || mem_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL wr_issue: gnt1=%b wr=%b wdata=%h want 1 1 00001234",
                     r1_gnt, mem_wr_en, mem_wdata);
        end
        tick();
        idle_inputs();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h20;
        @(negedge clk);
        checks++;
        if (r0_gnt !== 1'b1 || mem_rd_en !== 1'b1 || r1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_issue: gnt0=%b rd=%b rv1=%b want 1 1 0", r0_gnt, mem_rd_en, r1_rvalid);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h1234 || r1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_data: rv0=%b d0=%h rv1=%b want 1 00001234 0",
                     r0_rvalid, r0_rdata, r1_rvalid);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int prev;
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            int p;
            p = k % 2;
            idle_inputs();
            if (p == 0) begin r0_req = 1'b1; r0_addr = 32'h0; end
            else        begin r1_req = 1'b1; r1_addr = 32'h4; end
            @(negedge clk);
            checks++;
            if (r0_gnt !== (p == 0) || r1_gnt !== (p == 1) || mem_rd_en !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gnt%0d: gnt0=%b gnt1=%b rd=%b want port %0d", k, r0_gnt, r1_gnt, mem_rd_en, p);
            end
            if (prev >= 0) begin
                checks++;
                if (prev == 0 ? (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0 || r0_rdata !== 32'hC0DE_0000)
                              : (r1_rvalid !== 1'b1 || r0_rvalid !== 1'b0 || r1_rdata !== 32'hC0DE_0004)) begin
                    errors++;
                    $display("FAIL b2b_data%0d: rv0=%b d0=%h rv1=%b d1=%h want port %0d",
                             k, r0_rvalid, r0_rdata, r1_rvalid, r1_rdata, prev);
                end
            end
            prev = p;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (r1_rvalid !== 1'b1 || r0_rvalid !== 1'b0 || r1_rdata !== 32'hC0DE_0004 || r0_rdata !== 32'd0) begin
            errors++;
            $display("FAIL b2b_last: rv0=%b d0=%h rv1=%b d1=%h want 0 0 1 c0de0004",
                     r0_rvalid, r0_rdata, r1_rvalid, r1_rdata);
        end
        tick();
    endtask

    task automatic test_reset_inflight;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h0;
        @(negedge clk);
        checks++;
        if (r0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_gnt: gnt0=%b want 1", r0_gnt);
        end
        tick();
        reset = 1'b1;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h8;
        @(negedge clk);
        checks++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_rd_en, mem_wr_en} !== 6'b0 || mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL rst_inflight: flags=%b addr=%h want 000000 0",
                     {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_rd_en, mem_wr_en}, mem_addr);
        end
        tick();
        idle_inputs();
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_dropped: rv0=%b rv1=%b want 0 0", r0_rvalid, r1_rvalid);
        end
        tick();
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock;
        pulse_reset();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h90; r0_lock = 1'b1;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h94;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
                errors++;
                $display("FAIL lock_cycle%0d: gnt0=%b gnt1=%b want 1 0", c, r0_gnt, r1_gnt);
            end
            tick();
        end
        r0_req = 1'b0; r0_lock = 1'b0;
        @(negedge clk);
        checks++;
        if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: gnt0=%b gnt1=%b want 0 1", r0_gnt, r1_gnt);
        end
        tick();
        idle_inputs();
        tick();
    endtask
`endif

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        mem_init = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        mem_init = 1'b0;
        reset    = 1'b0;
        tick();
        test_single_read();
        test_contention();
        test_write_then_read();
        test_back_to_back();
        test_reset_inflight();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
